apb_cmd_master: RTL

//  APB4 requester on pclk that sits directly upstream of the APB register bridge.

---
 rtl/apb_cmd_master.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/apb_cmd_master.sv
// Purpose : APB4 requester; turns one valid/ready command into one APB transfer and one response.
// Latency : accept at edge N -> SETUP in N+1 -> ACCESS from N+2 -> rsp_valid in N+3 (+1 per wait-state).
// Backpr. : cmd_ready only in IDLE (no queueing); response held stable until rsp_ready; pready stretches ACCESS.
//
// Ports:
//   pclk, preset_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_write/
//   cmd_addr/cmd_wdata/cmd_strb          command request port
//   rsp_valid/rsp_ready/rsp_rdata/
//   rsp_err/rsp_timeout                  response port
//   psel/penable/pwrite/paddr/pwdata/
//   pstrb/pready/prdata/pslverr          APB4 requester interface
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [31:0]           pwdata,
  output logic [3:0]            pstrb,
  input  logic                  pready,
  input  logic [31:0]           prdata,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TO_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt, cnt_inc;
  logic                  timeout_hit;

  logic                  cmd_ready_nxt, psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_WIDTH-1:0] paddr_nxt;
  logic [31:0]           pwdata_nxt, rsp_rdata_nxt;
  logic [3:0]            pstrb_nxt;
  logic                  rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;

  // cnt counts ACCESS cycles already spent without pready; the abort fires in
  // the cycle where this idle cycle would bring it up to TIMEOUT_CYCLES.
  assign cnt_inc     = cnt + CNT_WIDTH'(1);
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_inc == TO_LIMIT);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    cmd_ready_nxt   = cmd_ready;
    psel_nxt        = psel;
    penable_nxt     = penable;
    pwrite_nxt      = pwrite;
    paddr_nxt       = paddr;
    pwdata_nxt      = pwdata;
    pstrb_nxt       = pstrb;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;

    case (state)
      S_IDLE: begin
        cmd_ready_nxt = 1'b1;
        if (cmd_valid && cmd_ready) begin
          state_nxt     = S_SETUP;
          cmd_ready_nxt = 1'b0;
          psel_nxt      = 1'b1;
          penable_nxt   = 1'b0;
          pwrite_nxt    = cmd_write;
          paddr_nxt     = cmd_addr;
          pwdata_nxt    = cmd_wdata;
          pstrb_nxt     = cmd_write ? cmd_strb : 4'h0;
          cnt_nxt       = '0;
        end
      end
      S_SETUP: begin
        state_nxt   = S_ACCESS;
        penable_nxt = 1'b1;
      end
      S_ACCESS: begin
        // pready wins over a timeout landing in the same cycle.
        if (pready) begin
          state_nxt       = S_RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = pslverr;
          rsp_timeout_nxt = 1'b0;
          rsp_rdata_nxt   = (!pwrite && !pslverr) ? prdata : 32'h0;
        end else if (timeout_hit) begin
          state_nxt       = S_RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_rdata_nxt   = 32'h0;
          cnt_nxt         = cnt_inc;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt       = S_IDLE;
          cmd_ready_nxt   = 1'b1;
          rsp_valid_nxt   = 1'b0;
          rsp_err_nxt     = 1'b0;
          rsp_timeout_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt         <= '0;
      cmd_ready   <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= 32'h0;
      pstrb       <= 4'h0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'h0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      cmd_ready   <= cmd_ready_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      pwrite      <= pwrite_nxt;
      paddr       <= paddr_nxt;
      pwdata      <= pwdata_nxt;
      pstrb       <= pstrb_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

endmodule
